// File: rtl/adder_pkg.sv
// Shared definitions for the AXI4-Lite adder peripheral: register word offsets,
// response codes and the write/read channel state types.
package adder_pkg;

    localparam logic [1:0] ADDR_OP_A   = 2'd0;
    localparam logic [1:0] ADDR_OP_B   = 2'd1;
    localparam logic [1:0] ADDR_SUM    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Only OP_A and OP_B accept writes; SUM and STATUS are read-only.
    function automatic logic is_writable(input logic [1:0] sel);
        return (sel == ADDR_OP_A) || (sel == ADDR_OP_B);
    endfunction

endpackage

// File: rtl/axil_adder_core.sv
// Operand registers with per-byte write enables, and a registered adder that
// produces SUM plus carry-out one cycle after the operands change.
module axil_adder_core
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [1:0]              wr_sel_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic [DATA_WIDTH-1:0]   op_a_o,
    output logic [DATA_WIDTH-1:0]   op_b_o,
    output logic [DATA_WIDTH-1:0]   sum_o,
    output logic                    carry_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  carry_q, carry_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wr_en_i && wr_strb_i[i]) begin
                if (wr_sel_i == ADDR_OP_A) op_a_d[i*8 +: 8] = wr_data_i[i*8 +: 8];
                if (wr_sel_i == ADDR_OP_B) op_b_d[i*8 +: 8] = wr_data_i[i*8 +: 8];
            end
        end
        // Sum is formed from the registered operands, so it trails an operand write by one cycle.
        {carry_d, sum_d} = {1'b0, op_a_q} + {1'b0, op_b_q};
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign op_a_o  = op_a_q;
    assign op_b_o  = op_b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/axil_adder.sv
// AXI4-Lite slave wrapper around the adder core: independent write and read
// channel FSMs, word-decoded on address bits [3:2].
module axil_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic                    s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic                  bresp_q, bresp_d;
    logic                  rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  core_wr_en;
    logic [1:0]            w_sel, r_sel;
    logic [DATA_WIDTH-1:0] op_a, op_b, sum;
    logic                  carry;
    logic                  unused_addr_bits;

    assign w_sel = s1_axi_awaddr[3:2];
    assign r_sel = s1_axi_araddr[3:2];
    assign unused_addr_bits = ^{s1_axi_awaddr, s1_axi_araddr};

    axil_adder_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk_i     (s1_axi_aclk),
        .rst_i     (s1_axi_areset),
        .wr_en_i   (core_wr_en),
        .wr_sel_i  (w_sel),
        .wr_data_i (s1_axi_wdata),
        .wr_strb_i (s1_axi_wstrb),
        .op_a_o    (op_a),
        .op_b_o    (op_b),
        .sum_o     (sum),
        .carry_o   (carry)
    );

    // Write channel: address and data are taken together in a single cycle only.
    always_comb begin
        w_state_d      = w_state_q;
        bresp_d        = bresp_q;
        s1_axi_awready = 1'b0;
        s1_axi_wready  = 1'b0;
        core_wr_en     = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s1_axi_awvalid && s1_axi_wvalid) begin
                    s1_axi_awready = 1'b1;
                    s1_axi_wready  = 1'b1;
                    core_wr_en     = is_writable(w_sel);
                    bresp_d        = is_writable(w_sel) ? RESP_OKAY : RESP_SLVERR;
                    w_state_d      = W_RESP;
                end
            end
            W_RESP: begin
                if (s1_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: rdata is captured from current register values at the accept edge,
    // so a read coinciding with an operand write sees the pre-write value.
    always_comb begin
        r_state_d      = r_state_q;
        rresp_d        = rresp_q;
        rdata_d        = rdata_q;
        s1_axi_arready = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (s1_axi_arvalid) begin
                    s1_axi_arready = 1'b1;
                    rresp_d        = RESP_OKAY;
                    r_state_d      = R_DATA;
                    unique case (r_sel)
                        ADDR_OP_A: rdata_d = op_a;
                        ADDR_OP_B: rdata_d = op_b;
                        ADDR_SUM:  rdata_d = sum;
                        default:   rdata_d = DATA_WIDTH'(carry);
                    endcase
                end
            end
            R_DATA: begin
                if (s1_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s1_axi_bvalid = (w_state_q == W_RESP);
    assign s1_axi_bresp  = bresp_q;
    assign s1_axi_rvalid = (r_state_q == R_DATA);
    assign s1_axi_rresp  = rresp_q;
    assign s1_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axil_adder.sv
// Self-checking bench for axil_adder: directed vector table, handshake corner
// sequences and randomized traffic against a plain-arithmetic register model.
module tb_axil_adder;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic          arvalid, arready, rresp, rvalid, rready;

    int checks = 0;
    int errors = 0;
    int aw_accepts = 0;

    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    always #5 clk = ~clk;

    axil_adder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .s1_axi_aclk    (clk),
        .s1_axi_areset  (areset),
        .s1_axi_awaddr  (awaddr),
        .s1_axi_awvalid (awvalid),
        .s1_axi_awready (awready),
        .s1_axi_wdata   (wdata),
        .s1_axi_wstrb   (wstrb),
        .s1_axi_wvalid  (wvalid),
        .s1_axi_wready  (wready),
        .s1_axi_bresp   (bresp),
        .s1_axi_bvalid  (bvalid),
        .s1_axi_bready  (bready),
        .s1_axi_araddr  (araddr),
        .s1_axi_arvalid (arvalid),
        .s1_axi_arready (arready),
        .s1_axi_rdata   (rdata),
        .s1_axi_rresp   (rresp),
        .s1_axi_rvalid  (rvalid),
        .s1_axi_rready  (rready)
    );

    always @(negedge clk) if (awvalid && awready) aw_accepts++;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out, expected within 20 cycles", name);
    endtask

    // Register model: byte-enabled operand writes, sum/carry from plain 33-bit arithmetic.
    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        for (int i = 0; i < 4; i++) begin
            if (strb[i] && addr[3:2] == 2'd0) m_a[i*8 +: 8] = data[i*8 +: 8];
            if (strb[i] && addr[3:2] == 2'd1) m_b[i*8 +: 8] = data[i*8 +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        logic [32:0] total;
        total = {1'b0, m_a} + {1'b0, m_b};
        case (addr[3:2])
            2'd0:    return m_a;
            2'd1:    return m_b;
            2'd2:    return total[31:0];
            default: return {31'b0, total[32]};
        endcase
    endfunction

    // All bus tasks start and end just after a rising edge.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
        if (!(awready && wready)) begin
            timeout("write_accept");
            awvalid = 1'b0; wvalid = 1'b0; resp = 1'bx;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin timeout("write_resp"); resp = 1'bx; return; end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) begin
            timeout("read_accept");
            arvalid = 1'b0; data = 'x; resp = 1'bx;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!rvalid) begin timeout("read_data"); data = 'x; resp = 1'bx; return; end
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        logic        resp, rresp_v;
        logic [31:0] d, exp_d;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          acc0;

        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        areset = 1'b0;

        // Reset state
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rdata", rdata, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(i * 4), d, rresp_v);
            check($sformatf("rst_read_%0h", i * 4), d, 0);
            check($sformatf("rst_rresp_%0h", i * 4), rresp_v, 0);
        end

        // Directed vector table
        vecs.push_back('{1, 8'h00, 32'h5,        4'hF, 0, 0});
        vecs.push_back('{1, 8'h04, 32'h7,        4'hF, 0, 0});
        vecs.push_back('{0, 8'h08, 0,            0,    0, 32'd12});
        vecs.push_back('{0, 8'h0C, 0,            0,    0, 32'd0});
        vecs.push_back('{1, 8'h00, 32'hFFFFFFFF, 4'hF, 0, 0});
        vecs.push_back('{1, 8'h04, 32'h1,        4'hF, 0, 0});
        vecs.push_back('{0, 8'h08, 0,            0,    0, 32'h0});
        vecs.push_back('{0, 8'h0C, 0,            0,    0, 32'h1});
        vecs.push_back('{1, 8'h00, 32'h11223344, 4'hF, 0, 0});
        vecs.push_back('{1, 8'h00, 32'hAABBCCDD, 4'h5, 0, 0});
        vecs.push_back('{0, 8'h00, 0,            0,    0, 32'h11BB33DD});
        vecs.push_back('{1, 8'h08, 32'hDEADBEEF, 4'hF, 1, 0});
        vecs.push_back('{0, 8'h08, 0,            0,    0, 32'h11BB33DE});
        vecs.push_back('{1, 8'h0C, 32'h1,        4'hF, 1, 0});
        vecs.push_back('{0, 8'h0C, 0,            0,    0, 32'h0});
        vecs.push_back('{0, 8'h07, 0,            0,    0, 32'h1});
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, rresp_v);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), rresp_v, 0);
            end
        end

        // wvalid leads awvalid by 3 cycles; bready held low 5 cycles with valids still asserted
        awaddr = 8'h04; wdata = 32'h0000_00A5; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_wready", wready, 0);
            check("wait_awready", awready, 0);
        end
        @(posedge clk); #1;
        acc0 = aw_accepts;
        awvalid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", bvalid, 1);
            check("hold_bresp", bresp, 0);
            check("hold_no_accept", awready, 0);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("single_accept", aw_accepts - acc0, 1);
        check("bvalid_cleared", bvalid, 0);
        model_write(8'h04, 32'h0000_00A5, 4'hF);

        // rready held low 5 cycles
        araddr = 8'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid", rvalid, 1);
            check("rhold_rdata", rdata, model_read(8'h04));
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_cleared", rvalid, 0);

        // Simultaneous write and read of OP_A: read sees the pre-write value
        exp_d = model_read(8'h00);
        fork
            axi_write(8'h00, 32'h0BAD_F00D, 4'hF, resp);
            axi_read(8'h00, d, rresp_v);
        join
        check("simul_rdata", d, exp_d);
        check("simul_bresp", resp, 0);
        model_write(8'h00, 32'h0BAD_F00D, 4'hF);
        axi_read(8'h00, d, rresp_v);
        check("simul_after", d, model_read(8'h00));

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            a  = 8'($urandom_range(0, 15));
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, wd, st, resp);
                check($sformatf("rnd%0d_bresp", i), resp, (a[3:2] >= 2'd2) ? 1'b1 : 1'b0);
                model_write(a, wd, st);
            end else begin
                axi_read(a, d, rresp_v);
                check($sformatf("rnd%0d_rdata_%0h", i, a), d, model_read(a));
            end
        end

        // Reset mid-transaction: pending responses vanish, registers clear
        awaddr = 8'h00; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("mid_bvalid", bvalid, 1);
        check("mid_rvalid", rvalid, 1);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        check("abort_bvalid", bvalid, 0);
        check("abort_rvalid", rvalid, 0);
        check("abort_rdata", rdata, 0);
        m_a = '0; m_b = '0;
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(i * 4), d, rresp_v);
            check($sformatf("post_rst_%0h", i * 4), d, model_read(8'(i * 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
